count_change_monitor: RTL
=========================

Name: count_change_monitor

Overview:
- Downstream consumer of the 4-bit counter output.
- Samples the count every clock and detects value changes.
- Each change is logged as an event record {previous value, new value, cycles the previous value was held}.
- Records are queued in a small show-ahead FIFO and drained by a valid/ready consumer (scoreboard, logger or bus bridge).

Parameters:
- WIDTH, 4, width of the sampled count and of the prev/curr fields.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RUN_W, 8, width of the hold-run field; saturating.

Ports:
- clk  input  1  rising-edge clock; all state is in this domain.
- rst  input  1  asynchronous, active-low reset; assert asynchronously, deassert synchronously externally.
- count_in  input  WIDTH  counter value, sampled on every rising edge.
- ev_valid  output  1  FIFO non-empty.
- ev_ready  input  1  consumer accepts the head record.
- ev_prev  output  WIDTH  head record: value before the change.
- ev_curr  output  WIDTH  head record: value after the change.
- ev_run  output  RUN_W  head record: edges the previous value was held.
- level  output  clog2(DEPTH)+1  number of stored records.
- overflow  output  1  sticky flag: a record was dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst=0, async): prev_q=0, primed=0, run_q=0, FIFO pointers=0, level=0, overflow=0. ev_valid=0; ev_prev/ev_curr/ev_run=0. Any queued records are discarded.
- Priming: the first edge after reset release loads prev_q=count_in, sets primed=1 and run_q=1. No event is generated on that edge.
- Hold: on a primed edge with count_in==prev_q, run_q increments and saturates at 2^RUN_W-1.
- Change: on a primed edge with count_in!=prev_q:
  - The record {prev_q, count_in, run_q} is pushed.
  - prev_q is loaded with count_in.
  - run_q is set to 1.
- Latency: a change sampled at edge N gives ev_valid=1 immediately after edge N if the FIFO was empty.
- Pop: occurs when ev_valid && ev_ready at an edge; the head pointer advances.
- Outputs are show-ahead: the ev_* fields reflect the head entry combinationally from storage and are forced to 0 when ev_valid=0.
- Full with push and pop on the same edge: both take effect; level is unchanged and no drop occurs.
- Full with push and no pop: the record is dropped, overflow is set, and stored contents are unchanged.
- Empty with ev_ready=1: no effect, no underflow.
- overflow stays set until clr_ovf=1 at an edge. If a drop and clr_ovf coincide, set wins.
- Pointers have clog2(DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the remaining bits are equal.
- Level is updated by +1 (push only), -1 (pop only) or 0.
- Mid-operation reset: all state is cleared immediately. The first edge after release re-primes, so a reset never produces a spurious event.

Decomposition:
- Shared package/include count_mon_pkg:
  - record field order {prev, curr, run};
  - default WIDTH/DEPTH/RUN_W constants;
  - clog2 function.
- One sub-module, cm_event_fifo: the synchronous show-ahead FIFO with push, pop, full, empty and level, using the same clk/rst.
- Change detection and run counting stay in the top level.

Test Plan:
- Reset, then count_in=0 for edges 1-3 and 2 from edge 4 -> one record {0,2,3}; ev_valid rises after edge 4; level=1.
- ev_ready=0; count_in alternates 1,2 every edge after priming on 1 (5 changes) -> records {1,2,1},{2,1,1},{1,2,1},{2,1,1} kept; 5th dropped; level=4; overflow=1. Then ev_ready=1 -> 4 pops in order; ev_valid falls after the 4th; overflow stays 1 until clr_ovf.
- FIFO full; on the same edge a change arrives and ev_ready=1 -> no drop; level stays 4; new record is at the tail.
- count_in held at 5 for 300 edges, then set to 6 -> record {5,6,255} (saturated).
- rst asserted mid-stream with 3 records queued -> level=0, ev_valid=0, all ev_* fields 0 immediately. After release, count_in=2 held, then 3 -> only {2,3,n} is produced; no {x,2} event.
- Drop and clr_ovf on the same edge -> overflow=1; a later clr_ovf with no drop -> overflow=0.

Source files
------------

// File: rtl/count_mon_pkg.sv
// Shared types and constants for the count change monitor.
// Event records are packed {prev, curr, run}, with prev in the MSBs.
package count_mon_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefRunW  = 8;

  typedef enum logic {
    StPrime,
    StRun
  } prime_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res++;
    end
    return res;
  endfunction

  function automatic int unsigned rec_width(input int unsigned width, input int unsigned run_w);
    return 2 * width + run_w;
  endfunction

endpackage

// File: rtl/cm_event_fifo.sv
// Synchronous show-ahead FIFO for event records.
// A push while full is accepted only when a pop frees the slot on the same edge.
module cm_event_fifo
  import count_mon_pkg::*;
#(
  parameter int unsigned DataW = rec_width(DefWidth, DefRunW),
  parameter int unsigned Depth = DefDepth,
  localparam int unsigned PtrW = clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DataW-1:0] wdata,
  input  logic             pop,
  output logic [DataW-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PtrW-1:0]  level
);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[PtrW-2:0]];
  assign level   = level_q;

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + PtrW'(1);
      2'b01:   level_d = level_q - PtrW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

  // Storage needs no reset: reads are masked by empty at the top level.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-2:0]] <= wdata;
  end

endmodule

// File: rtl/count_change_monitor.sv
// Samples a counter every edge and queues {prev, curr, run} records on each value change.
// The first edge after reset only primes the reference value, so resets never emit events.
module count_change_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned RUN_W = DefRunW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   count_in,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [WIDTH-1:0]   ev_prev,
  output logic [WIDTH-1:0]   ev_curr,
  output logic [RUN_W-1:0]   ev_run,
  output logic [clog2(DEPTH):0] level,
  output logic               overflow,
  input  logic               clr_ovf
);

  localparam int unsigned RecW = rec_width(WIDTH, RUN_W);

  prime_state_e     state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, drop, full, empty;
  logic [RecW-1:0]  wdata, rdata;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    push    = 1'b0;
    unique case (state_q)
      StPrime: begin
        state_d = StRun;
        prev_d  = count_in;
        run_d   = RUN_W'(1);
      end
      StRun: begin
        if (count_in != prev_q) begin
          push   = 1'b1;
          prev_d = count_in;
          run_d  = RUN_W'(1);
        end else if (run_q != '1) begin
          run_d = run_q + RUN_W'(1);
        end
      end
      default: state_d = StPrime;
    endcase
  end

  assign wdata = {prev_q, count_in, run_q};
  assign pop   = ev_valid && ev_ready;
  assign drop  = push && full && !pop;

  // A drop on the same edge as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StPrime;
      prev_q  <= '0;
      run_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      ovf_q   <= ovf_d;
    end
  end

  cm_event_fifo #(
    .DataW(RecW),
    .Depth(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(wdata),
    .pop  (pop),
    .rdata(rdata),
    .full (full),
    .empty(empty),
    .level(level)
  );

  assign ev_valid = !empty;
  assign overflow = ovf_q;

  always_comb begin
    {ev_prev, ev_curr, ev_run} = '0;
    if (ev_valid) begin
      {ev_prev, ev_curr, ev_run} = rdata;
    end
  end

endmodule
